// File: rtl/charge_session_manager.sv
// rtl/charge_session_manager.sv - prepaid charging session FSM: digit entry, timed run, pause, cancel
// Money is entered as decimal digits, converted to time units and counted down on a prescaled tick.

module charge_session_manager #(
  parameter int TICK_DIV       = 50000000,
  parameter int MAX_AMOUNT     = 20,
  parameter int UNITS_PER_COIN = 2,
  parameter int DIGITS         = 2,
  parameter int AMT_W          = 5,
  parameter int TIME_W         = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  input  logic [3:0]        key_value,
  input  logic              start,
  input  logic              cancel,
  input  logic              pause,
  output logic [AMT_W-1:0]  amount,
  output logic [TIME_W-1:0] remaining,
  output logic              timing,
  output logic              paused,
  output logic              done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int EW = AMT_W + 5;
  localparam int MW = AMT_W + TIME_W;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [EW-1:0]    MAX_EXT   = EW'(MAX_AMOUNT);
  localparam logic [AMT_W-1:0] MAX_AMT   = AMT_W'(MAX_AMOUNT);
  localparam logic [1:0]       DIG_MAX   = 2'(DIGITS);

  typedef enum logic [1:0] {IDLE, ENTRY, RUN, HOLD} state_t;

  state_t            state_q, state_d;
  logic [1:0]        sync_q;
  logic [PW-1:0]     presc_q, presc_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [AMT_W-1:0]  amount_d;
  logic [TIME_W-1:0] remaining_d;
  logic              timing_d, paused_d, done_d;

  logic              do_cancel, do_start, do_pause, do_key;
  logic [EW-1:0]     entry_val, first_val;
  logic [AMT_W-1:0]  entry_sat, first_sat;
  logic [MW-1:0]     load_val;

  // Reset asserts immediately; release is delayed two edges so the first active edge is clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], 1'b1};
  end

  // One winning strobe per cycle; a masked strobe is dropped even if the winner has no effect.
  always_comb begin
    do_cancel = cancel;
    do_start  = start & ~cancel;
    do_pause  = pause & ~cancel & ~start;
    do_key    = key_valid & ~cancel & ~start & ~pause & (key_value <= 4'd9);
  end

  always_comb begin
    entry_val = EW'(amount) * EW'(10) + EW'(key_value);
    first_val = EW'(key_value);
    entry_sat = (entry_val > MAX_EXT) ? MAX_AMT : entry_val[AMT_W-1:0];
    first_sat = (first_val > MAX_EXT) ? MAX_AMT : first_val[AMT_W-1:0];
    load_val  = MW'(amount) * MW'(UNITS_PER_COIN);
  end

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    cnt_d       = cnt_q;
    amount_d    = amount;
    remaining_d = remaining;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (do_key && key_value != 4'd0) begin
          amount_d = first_sat;
          cnt_d    = 2'd1;
          state_d  = ENTRY;
        end
      end
      ENTRY: begin
        if (do_cancel) begin
          amount_d = '0;
          cnt_d    = 2'd0;
          state_d  = IDLE;
        end else if (do_start) begin
          remaining_d = load_val[TIME_W-1:0];
          presc_d     = '0;
          state_d     = RUN;
        end else if (do_key && cnt_q < DIG_MAX) begin
          amount_d = entry_sat;
          cnt_d    = cnt_q + 2'd1;
        end
      end
      RUN: begin
        if (do_cancel) begin
          amount_d    = '0;
          remaining_d = '0;
          cnt_d       = 2'd0;
          state_d     = IDLE;
        end else if (do_pause) begin
          state_d = HOLD;
        end else if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          if (remaining == TIME_W'(1)) begin
            remaining_d = '0;
            amount_d    = '0;
            cnt_d       = 2'd0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end else if (remaining != '0) begin
            remaining_d = remaining - TIME_W'(1);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      HOLD: begin
        if (do_cancel) begin
          amount_d    = '0;
          remaining_d = '0;
          cnt_d       = 2'd0;
          state_d     = IDLE;
        end else if (do_pause) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    // Held in the reset state until the synchronised release reaches the last stage.
    if (!sync_q[1]) begin
      state_d     = IDLE;
      presc_d     = '0;
      cnt_d       = 2'd0;
      amount_d    = '0;
      remaining_d = '0;
      done_d      = 1'b0;
    end

    timing_d = (state_d == RUN) || (state_d == HOLD);
    paused_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      cnt_q     <= 2'd0;
      amount    <= '0;
      remaining <= '0;
      timing    <= 1'b0;
      paused    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      amount    <= amount_d;
      remaining <= remaining_d;
      timing    <= timing_d;
      paused    <= paused_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_charge_session_manager.sv
// tb/tb_charge_session_manager.sv - directed vector bench for charge_session_manager (TICK_DIV=4)

module tb_charge_session_manager;

  logic       clk;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_value;
  logic       start;
  logic       cancel;
  logic       pause;
  logic [4:0] amount;
  logic [5:0] remaining;
  logic       timing;
  logic       paused;
  logic       done;

  int checks;
  int failures;
  int done_pulses;

  charge_session_manager #(
    .TICK_DIV(4), .MAX_AMOUNT(20), .UNITS_PER_COIN(2),
    .DIGITS(2), .AMT_W(5), .TIME_W(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_value(key_value),
    .start(start), .cancel(cancel), .pause(pause), .amount(amount),
    .remaining(remaining), .timing(timing), .paused(paused), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_pulses++;

  typedef struct {
    logic       kv;
    logic [3:0] kval;
    logic       st;
    logic       cn;
    logic       pa;
    int         amt;
    int         rem;
    logic       tim;
    logic       pau;
    logic       dn;
  } vec_t;

  vec_t tbl[29];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_all(input string name, input int amt, input int rem,
                           input int tim, input int pau, input int dn);
    check({name, " amount"}, int'(amount), amt);
    check({name, " remaining"}, int'(remaining), rem);
    check({name, " timing"}, int'(timing), tim);
    check({name, " paused"}, int'(paused), pau);
    check({name, " done"}, int'(done), dn);
  endtask

  // Called at a negedge: drive for one rising edge, land on the next negedge.
  task automatic apply(input logic kv, input logic [3:0] kval, input logic st,
                       input logic cn, input logic pa);
    key_valid = kv; key_value = kval; start = st; cancel = cn; pause = pa;
    @(negedge clk);
    key_valid = 1'b0; key_value = 4'd0; start = 1'b0; cancel = 1'b0; pause = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; failures = 0; done_pulses = 0;
    rst_n = 1'b0; key_valid = 1'b0; key_value = 4'd0;
    start = 1'b0; cancel = 1'b0; pause = 1'b0;

    //          kv    kval   st    cn    pa    amt rem tim   pau   dn
    tbl[0]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 0,  0,  1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 0,  0,  1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 0,  0,  1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 4'd4,  1'b0, 1'b0, 1'b0, 4,  0,  1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 4,  0,  1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 20, 0,  1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 20, 0,  1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 4'd3,  1'b1, 1'b1, 1'b0, 0,  0,  1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 0,  0,  1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 0,  0,  1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 3,  0,  1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 20, 0,  1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 20, 0,  1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 20, 40, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 20, 40, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 20, 40, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 20, 40, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 20, 39, 1'b1, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 20, 39, 1'b1, 1'b1, 1'b0};
    tbl[19] = '{1'b1, 4'd2,  1'b1, 1'b0, 1'b0, 20, 39, 1'b1, 1'b1, 1'b0};
    tbl[20] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 20, 39, 1'b1, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 20, 39, 1'b1, 1'b0, 1'b0};
    tbl[22] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 20, 39, 1'b1, 1'b0, 1'b0};
    tbl[23] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 20, 39, 1'b1, 1'b0, 1'b0};
    tbl[24] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 20, 38, 1'b1, 1'b0, 1'b0};
    tbl[25] = '{1'b1, 4'd1,  1'b0, 1'b1, 1'b1, 0,  0,  1'b0, 1'b0, 1'b0};
    tbl[26] = '{1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 1,  0,  1'b0, 1'b0, 1'b0};
    tbl[27] = '{1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 15, 0,  1'b0, 1'b0, 1'b0};
    tbl[28] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 15, 30, 1'b1, 1'b0, 1'b0};

    #23;
    check_all("in_reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    for (int i = 0; i < 29; i++) begin
      apply(tbl[i].kv, tbl[i].kval, tbl[i].st, tbl[i].cn, tbl[i].pa);
      check_all($sformatf("vec%0d", i), tbl[i].amt, tbl[i].rem,
                int'(tbl[i].tim), int'(tbl[i].pau), int'(tbl[i].dn));
    end

    // Full 15-coin session: tick every 4 clk, done 120 clk after start.
    for (int c = 1; c <= 121; c++) begin
      idle(1);
      if (c < 120) begin
        check($sformatf("run c%0d remaining", c), int'(remaining), 30 - c / 4);
        check($sformatf("run c%0d done", c), int'(done), 0);
      end else if (c == 120) begin
        check_all("final_tick", 0, 0, 0, 0, 1);
      end else begin
        check_all("after_done", 0, 0, 0, 0, 0);
      end
    end

    // Pause holds for 20 clk and resumes at the frozen prescaler phase (2).
    apply(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    check("pause_load remaining", int'(remaining), 10);
    idle(2);
    apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 20; c++) begin
      idle(1);
      check($sformatf("hold c%0d remaining", c), int'(remaining), 10);
      check($sformatf("hold c%0d paused", c), int'(paused), 1);
    end
    apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    check_all("resume", 5, 10, 1, 0, 0);
    idle(1);
    check("resume+1 remaining", int'(remaining), 10);
    idle(1);
    check("resume+2 remaining", int'(remaining), 9);
    apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    check_all("run_cancel", 0, 0, 0, 0, 0);

    // Cancel on the final tick edge wins: no done.
    apply(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    check("cancel_tick load", int'(remaining), 2);
    idle(7);
    check("cancel_tick pre", int'(remaining), 1);
    apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    check_all("cancel_tick", 0, 0, 0, 0, 0);
    idle(2);
    check("cancel_tick later done", int'(done), 0);

    // Asynchronous reset mid-run with remaining=7.
    apply(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(4);
    check("rst_pre remaining", int'(remaining), 7);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    check_all("post_rst", 0, 0, 0, 0, 0);
    apply(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    check("post_rst key amount", int'(amount), 2);

    check("done_pulse_count", done_pulses, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/charge_session_manager.md
CHARGE_SESSION_MANAGER -- requirements
Module: charge_session_manager

Interface
REQ-001 Parameter TICK_DIV, default 50000000: clk cycles per timing tick (50 MHz to 1 Hz); legal range >=2.
REQ-002 Parameter MAX_AMOUNT, default 20: money saturation ceiling; legal range 1..999.
REQ-003 Parameter UNITS_PER_COIN, default 2: time units granted per money unit; legal range >=1.
REQ-004 Parameter DIGITS, default 2: maximum digits accepted per entry; legal range 1..3.
REQ-005 Parameter AMT_W, default 5: amount width; SHALL satisfy 2^AMT_W > MAX_AMOUNT.
REQ-006 Parameter TIME_W, default 6: remaining width; SHALL satisfy 2^TIME_W > MAX_AMOUNT*UNITS_PER_COIN.
REQ-007 clk  in  1  single system clock; all state updates on its rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 key_valid  in  1  one-cycle strobe: key_value is valid this cycle.
REQ-010 key_value  in  4  pressed digit; codes 10..15 SHALL be ignored.
REQ-011 start  in  1  one-cycle strobe: begin charging.
REQ-012 cancel  in  1  one-cycle strobe: abort entry or session.
REQ-013 pause  in  1  one-cycle strobe: toggle pause while charging.
REQ-014 amount  out  AMT_W  accepted money, binary.
REQ-015 remaining  out  TIME_W  remaining time units, binary.
REQ-016 timing  out  1  high in RUN and HOLD.
REQ-017 paused  out  1  high in HOLD only.
REQ-018 done  out  1  one-cycle pulse on natural session completion.

Function
REQ-019 The FSM SHALL have four states: IDLE, ENTRY, RUN, HOLD. All outputs SHALL be registered.
REQ-020 Strobe priority in a single cycle: cancel > start > pause > key_valid; lower-priority strobes that cycle SHALL be ignored.
REQ-021 IDLE: a valid key with a nonzero digit SHALL load amount=digit, set digit count=1 and go to ENTRY; digit 0, start and pause SHALL be ignored.
REQ-022 ENTRY, valid key with count<DIGITS: amount SHALL become min(amount*10+digit, MAX_AMOUNT) and count SHALL increment; intermediate arithmetic SHALL be wide enough not to overflow before the compare.
REQ-023 ENTRY, valid key with count==DIGITS: the key SHALL be ignored.
REQ-024 ENTRY, start: remaining SHALL load amount*UNITS_PER_COIN, the prescaler SHALL clear to 0 and the FSM SHALL go to RUN; amount SHALL be held.
REQ-025 ENTRY, cancel: amount SHALL clear to 0 and the FSM SHALL go to IDLE.
REQ-026 RUN: the prescaler SHALL count 0..TICK_DIV-1 and wrap; at each wrap, remaining SHALL decrement by 1.
REQ-027 RUN, tick with remaining==1: remaining SHALL become 0, the FSM SHALL go to IDLE, amount SHALL clear and done SHALL pulse high in the next cycle for exactly one cycle.
REQ-028 RUN, pause: the FSM SHALL go to HOLD; the prescaler SHALL freeze at its current value and no tick SHALL occur that cycle.
REQ-029 HOLD, pause: the FSM SHALL return to RUN and the prescaler SHALL resume from its frozen value.
REQ-030 HOLD: keys and start SHALL be ignored.
REQ-031 RUN or HOLD, cancel: remaining and amount SHALL clear, the FSM SHALL go to IDLE and done SHALL stay low.
REQ-032 RUN: keys and start SHALL be ignored; remaining SHALL never underflow below 0.
REQ-033 A cancel in the same cycle as the final tick SHALL win: no done pulse.

Reset
REQ-034 While rst_n is low, the FSM SHALL be in IDLE, and amount, remaining, prescaler and digit count SHALL be 0, and timing, paused and done SHALL be low, independent of clk.
REQ-035 Reset asserted mid-session SHALL abort immediately with no done pulse; release SHALL be synchronised internally so the first active edge is clean.

Verification (TICK_DIV=4, defaults otherwise)
REQ-036 Keys 1, 5, then start -> amount=15, remaining=30, timing=1; remaining decrements every 4 clk; done pulses once, 120 clk after start; amount=0 afterwards.
REQ-037 Keys 3, 7 -> amount=20 (saturated); a third key 9 -> amount stays 20; start -> remaining=40.
REQ-038 Keys 0, 0, 4 from IDLE -> leading zeros ignored, amount=4, state ENTRY.
REQ-039 Running with remaining=10, pause -> remaining holds for 20 clk with paused=1; pause again -> decrement resumes at the frozen prescaler phase.
REQ-040 Cancel coincident with the remaining 1->0 tick -> IDLE, remaining=0, done never asserted; cancel+start+key in the same cycle during ENTRY -> IDLE, amount=0.
REQ-041 rst_n pulsed low during RUN with remaining=7 -> all outputs 0 asynchronously, before the next clk edge; no done pulse.
